// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path.
//   ser_state_t   : serializer FSM state encoding (IDLE, SHIFT)
//   SER_WIDTH_DEF : default word width of the serializer
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/seq_serializer_if.sv
// Handshake and serial-stream bundle for seq_serializer.
//   data_in/data_valid/data_ready : parallel word handshake (source -> serializer)
//   shift_en                      : downstream pacing strobe
//   bit_out/bit_valid/word_last   : serial stream to the detector
//   busy                          : serializer activity flag
// master: the surroundings (source + consumer); slave: the serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             shift_en;
  logic             bit_out;
  logic             bit_valid;
  logic             word_last;
  logic             busy;

  modport master (
    output data_in, data_valid, shift_en,
    input  data_ready, bit_out, bit_valid, word_last, busy
  );

  modport slave (
    input  data_in, data_valid, shift_en,
    output data_ready, bit_out, bit_valid, word_last, busy
  );

endinterface

// File: rtl/ser_hold_reg.sv
// One-entry WIDTH-bit holding buffer with a full flag.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low clear
//   wr_i   : store d_i and set full
//   rd_i   : release the entry (clears full)
//   d_i    : write data
//   q_o    : stored word
//   full_o : entry occupied
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // The owner never writes while full, so write/read never collide;
  // write still wins if they ever do, so no word is dropped silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (wr_i) begin
      data_q <= d_i;
      full_q <= 1'b1;
    end else if (rd_i) begin
      full_q <= 1'b0;
    end
  end

  assign q_o    = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the serial sequence detectors.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_serializer_if slave (word handshake in, serial stream out)
// Words are loaded into a shift register and emitted one bit per shift_en
// cycle; a one-entry holding register lets consecutive words stream with no
// idle bit at the boundary.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  seq_serializer_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hold_wr, hold_rd, hold_full;
  logic [WIDTH-1:0] hold_q;

  logic             xfer;
  logic             consume;
  logic             end_word;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst_n  (reset),
    .wr_i   (hold_wr),
    .rd_i   (hold_rd),
    .d_i    (bus.data_in),
    .q_o    (hold_q),
    .full_o (hold_full)
  );

  assign bus.data_ready = !hold_full;
  assign xfer           = bus.data_valid && !hold_full;
  assign consume        = (state_q == SHIFT) && bus.shift_en;
  assign end_word       = consume && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // A word arriving at an end-of-word edge with the hold empty skips
        // the hold and goes straight into the shift register.
        if (xfer && !(end_word && !hold_full)) begin
          hold_wr = 1'b1;
        end

        if (consume) begin
          if (cnt_q != CNT_LAST) begin
            shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q + CNT_ONE;
          end else if (hold_full) begin
            shreg_d = hold_q;
            hold_rd = 1'b1;
            cnt_d   = '0;
          end else if (xfer) begin
            shreg_d = bus.data_in;
            cnt_d   = '0;
          end else begin
            // Clearing the register keeps bit_out at 0 while idle without
            // gating the output path.
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.bit_valid = (state_q == SHIFT);
  assign bus.bit_out   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign bus.word_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign bus.busy      = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: three configurations
// (WIDTH=5 MSB-first, WIDTH=8 MSB-first, WIDTH=5 LSB-first) on a shared
// clock and reset, exercised one after another from a single initial block.
module tb_seq_serializer;

  logic clk;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  seq_serializer_if #(.WIDTH(5)) if5  ();
  seq_serializer_if #(.WIDTH(8)) if8  ();
  seq_serializer_if #(.WIDTH(5)) if5l ();

  seq_serializer #(.WIDTH(5), .LSB_FIRST(1'b0)) u5 (
    .clk   (clk),
    .reset (reset),
    .bus   (if5.slave)
  );

  seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  seq_serializer #(.WIDTH(5), .LSB_FIRST(1'b1)) u5l (
    .clk   (clk),
    .reset (reset),
    .bus   (if5l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  w5a;
  logic [9:0]  b2b;
  logic [7:0]  a5;
  logic [7:0]  ff_word;
  logic [7:0]  f0_word;
  logic [23:0] bp_bits;
  logic [7:0]  words [3];
  int          idx;
  logic        fire;

  initial begin
    reset = 1'b0;
    if5.data_in  = '0; if5.data_valid  = 1'b0; if5.shift_en  = 1'b0;
    if8.data_in  = '0; if8.data_valid  = 1'b0; if8.shift_en  = 1'b0;
    if5l.data_in = '0; if5l.data_valid = 1'b0; if5l.shift_en = 1'b0;

    // ---------------- reset state ----------------
    #1;
    chk("rst_bit_out",    {31'd0, if5.bit_out},    32'd0);
    chk("rst_bit_valid",  {31'd0, if5.bit_valid},  32'd0);
    chk("rst_word_last",  {31'd0, if5.word_last},  32'd0);
    chk("rst_busy",       {31'd0, if5.busy},       32'd0);
    chk("rst_data_ready", {31'd0, if5.data_ready}, 32'd1);
    chk("rst8_data_ready", {31'd0, if8.data_ready}, 32'd1);
    #2 reset = 1'b1;

    // ---------------- single word, W=5, 11010 ----------------
    w5a = 5'b11010;
    if5.data_in = w5a; if5.data_valid = 1'b1; if5.shift_en = 1'b1;
    step();
    if5.data_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("single_valid_%0d", k), {31'd0, if5.bit_valid}, 32'd1);
      chk($sformatf("single_bit_%0d", k),   {31'd0, if5.bit_out},   {31'd0, w5a[4-k]});
      chk($sformatf("single_last_%0d", k),  {31'd0, if5.word_last}, (k == 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("single_idle_valid", {31'd0, if5.bit_valid}, 32'd0);
    chk("single_idle_bit",   {31'd0, if5.bit_out},   32'd0);
    chk("single_idle_busy",  {31'd0, if5.busy},      32'd0);

    // ---------------- back-to-back, W=5 ----------------
    b2b = 10'b1101001101;
    if5.data_in = 5'b11010; if5.data_valid = 1'b1;
    step();
    if5.data_in = 5'b01101;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("b2b_valid_%0d", k), {31'd0, if5.bit_valid}, 32'd1);
      chk($sformatf("b2b_bit_%0d", k),   {31'd0, if5.bit_out},   {31'd0, b2b[9-k]});
      if (k == 1) chk("b2b_ready_held",  {31'd0, if5.data_ready}, 32'd0);
      if (k == 1) chk("b2b_busy",        {31'd0, if5.busy},       32'd1);
      if (k == 5) chk("b2b_ready_again", {31'd0, if5.data_ready}, 32'd1);
      step();
      if (k == 0) if5.data_valid = 1'b0;
    end
    chk("b2b_idle_valid", {31'd0, if5.bit_valid}, 32'd0);

    // ---------------- stall, W=8, A5 ----------------
    a5 = 8'hA5;
    if8.data_in = a5; if8.data_valid = 1'b1; if8.shift_en = 1'b1;
    step();
    if8.data_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("stall_valid_%0d", k), {31'd0, if8.bit_valid}, 32'd1);
      chk($sformatf("stall_bit_%0d", k),   {31'd0, if8.bit_out},   {31'd0, a5[7-k/2]});
      chk($sformatf("stall_last_%0d", k),  {31'd0, if8.word_last}, (k >= 14) ? 32'd1 : 32'd0);
      if8.shift_en = (k % 2 == 1);
      step();
    end
    chk("stall_idle_valid", {31'd0, if8.bit_valid}, 32'd0);
    if8.shift_en = 1'b1;

    // ---------------- backpressure, W=8, three words ----------------
    words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h5A;
    bp_bits  = 24'h3CC35A;
    idx = 0;
    if8.data_in = words[0]; if8.data_valid = 1'b1;
    fire = if8.data_valid && if8.data_ready;
    step();
    if (fire) begin
      idx++;
      if (idx < 3) if8.data_in = words[idx]; else if8.data_valid = 1'b0;
    end
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'd0, if8.bit_valid}, 32'd1);
      chk($sformatf("bp_bit_%0d", k),   {31'd0, if8.bit_out},   {31'd0, bp_bits[23-k]});
      if (k == 1) chk("bp_ready_hold_full", {31'd0, if8.data_ready}, 32'd0);
      if (k == 7) chk("bp_ready_third_stall", {31'd0, if8.data_ready}, 32'd0);
      if (k == 8) chk("bp_ready_reopen", {31'd0, if8.data_ready}, 32'd1);
      fire = if8.data_valid && if8.data_ready;
      step();
      if (fire) begin
        idx++;
        if (idx < 3) if8.data_in = words[idx]; else if8.data_valid = 1'b0;
      end
    end
    chk("bp_idle_valid", {31'd0, if8.bit_valid}, 32'd0);
    chk("bp_idle_busy",  {31'd0, if8.busy},      32'd0);

    // ---------------- reset mid-word, W=8 ----------------
    ff_word = 8'hFF;
    if8.data_in = ff_word; if8.data_valid = 1'b1;
    step();
    if8.data_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_bit_%0d", k), {31'd0, if8.bit_out}, {31'd0, ff_word[7-k]});
      if (k < 2) step();
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_bit_out",    {31'd0, if8.bit_out},    32'd0);
    chk("mid_rst_bit_valid",  {31'd0, if8.bit_valid},  32'd0);
    chk("mid_rst_word_last",  {31'd0, if8.word_last},  32'd0);
    chk("mid_rst_busy",       {31'd0, if8.busy},       32'd0);
    chk("mid_rst_data_ready", {31'd0, if8.data_ready}, 32'd1);
    #2 reset = 1'b1;
    f0_word = 8'h0F;
    if8.data_in = f0_word; if8.data_valid = 1'b1;
    step();
    if8.data_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("post_valid_%0d", k), {31'd0, if8.bit_valid}, 32'd1);
      chk($sformatf("post_bit_%0d", k),   {31'd0, if8.bit_out},   {31'd0, f0_word[7-k]});
      chk($sformatf("post_last_%0d", k),  {31'd0, if8.word_last}, (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    chk("post_idle_valid", {31'd0, if8.bit_valid}, 32'd0);

    // ---------------- LSB-first, W=5, 11010 ----------------
    if5l.data_in = w5a; if5l.data_valid = 1'b1; if5l.shift_en = 1'b1;
    step();
    if5l.data_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lsb_valid_%0d", k), {31'd0, if5l.bit_valid}, 32'd1);
      chk($sformatf("lsb_bit_%0d", k),   {31'd0, if5l.bit_out},   {31'd0, w5a[k]});
      chk($sformatf("lsb_last_%0d", k),  {31'd0, if5l.word_last}, (k == 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("lsb_idle_valid", {31'd0, if5l.bit_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial stage directly upstream of the serial sequence detectors (e.g. the 11010 Mealy detector).
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on bit_out, which drives the detector's in_bit.
- A one-entry holding register allows back-to-back words to stream with no idle bit between them.

Parameters:
- WIDTH, 8, bits per word; minimum 2.
- LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  parallel word.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  advance the serial stream this cycle (pacing from downstream).
- bit_out  out  1  current serial bit; drives detector in_bit.
- bit_valid  out  1  bit_out holds a real data bit.
- word_last  out  1  bit_out is the final bit of its word.
- busy  out  1  a word is shifting or the holding register is occupied.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0, hold empty.
  - bit_out=0, bit_valid=0, word_last=0, busy=0, data_ready=1.
  - Any partial word is discarded and never resumed.
- Handshake:
  - A word transfers at a rising edge where data_valid && data_ready.
  - data_ready = !hold_full; it is a function of registered state only, never of data_valid.
- States: IDLE, SHIFT.
- IDLE:
  - On a transfer, load the word directly into the shift register, set cnt=0, go to SHIFT.
  - The first bit appears on bit_out the cycle after the transfer edge (1-cycle latency).
- SHIFT:
  - bit_valid=1.
  - bit_out = shreg[WIDTH-1] (MSB-first) or shreg[0] (LSB-first), driven directly from the register.
  - The consumer samples bit_out at an edge where bit_valid && shift_en.
  - At such an edge with cnt<WIDTH-1: shift by one toward the output end and increment cnt.
  - At such an edge with cnt==WIDTH-1 (end of word), the first matching case applies:
    - hold_full: load hold into shreg, clear hold, cnt=0, stay in SHIFT.
    - hold empty and a transfer on this edge: bypass, loading data_in straight into shreg; cnt=0, stay in SHIFT.
    - otherwise: go to IDLE; bit_valid=0 next cycle.
  - A transfer during SHIFT that is not consumed by the bypass sets hold_full.
- shift_en=0: shreg, cnt and state are frozen. bit_out, bit_valid and word_last hold their values. Transfers into the hold register are still accepted.
- word_last = bit_valid && (cnt==WIDTH-1).
- busy = (state==SHIFT) || hold_full.
- Width rules:
  - cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
  - Shifting fills vacated bits with 0.
- Throughput: with shift_en held at 1 and the source always valid, a WIDTH-bit word completes every WIDTH cycles with no gap.
- bit_out is 0 whenever bit_valid=0. The detector sees a stream of 0s when idle; this is accepted system behaviour.

Decomposition:
- Shared package seq_pkg:
  - State enum ser_state_t {IDLE, SHIFT}.
  - Default width constant SER_WIDTH_DEF=8.
- One natural sub-module: ser_hold_reg.
  - One-entry WIDTH-bit buffer with full flag, write/read strobes and asynchronous active-low clear.
- Shift/count FSM stays in the top level.

Test Plan:
- Reset then single word, WIDTH=5, LSB_FIRST=0, data_in=5'b11010, shift_en=1:
  - bit_out=1,1,0,1,0 on cycles 1..5 after the transfer.
  - word_last high only on cycle 5; bit_valid low on cycle 6.
  - Detector downstream asserts out on the fifth bit.
- Back-to-back, WIDTH=5, source always valid with 5'b11010 then 5'b01101:
  - 10 contiguous valid bits 1101001101.
  - data_ready drops while hold_full, and no bit_valid gap at the word boundary.
- Stall, WIDTH=8, data_in=8'hA5, shift_en toggling 1,0,1,0:
  - Each bit is held while shift_en=0.
  - Output sequence is 1,0,1,0,0,1,0,1 over 16 cycles.
- Backpressure: three words offered during one shift:
  - Second word goes to hold; third is stalled (data_ready=0) until the first word completes.
  - No word is lost or duplicated.
- Reset mid-word: assert reset after 3 bits of 8'hFF:
  - Outputs go to reset values immediately, without waiting for a clock.
  - After release, the new word 8'h0F shifts out fully with no residue from 8'hFF.
- LSB_FIRST=1, WIDTH=5, data_in=5'b11010:
  - bit_out=0,1,0,1,1.
